// File: rtl/fcvt_int_to_fp.sv
// Two-stage int32/uint32 to IEEE-754 binary32 converter with five rounding modes.
// Stage 1 takes the magnitude and leading-zero count; stage 2 normalizes, rounds and packs.
module fcvt_int_to_fp (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        valid_in,
    input  logic [31:0] src,
    input  logic        is_unsigned,
    input  logic [2:0]  round_mode,
    output logic        valid_out,
    output logic [31:0] result,
    output logic [4:0]  fflags
);

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    function automatic logic [4:0] clz32(input logic [31:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd0;
        found = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) begin
                    found = 1'b1;
                end else begin
                    n = n + 5'd1;
                end
            end else begin
                found = 1'b1;
            end
        end
        return n;
    endfunction

    logic        s1_valid_q, s1_valid_d;
    logic        s1_sign_q,  s1_sign_d;
    logic [31:0] s1_mag_q,   s1_mag_d;
    logic [4:0]  s1_lz_q,    s1_lz_d;
    logic        s1_zero_q,  s1_zero_d;
    logic [2:0]  s1_rm_q,    s1_rm_d;

    logic        valid_out_q, valid_out_d;
    logic [31:0] result_q,    result_d;
    logic [4:0]  fflags_q,    fflags_d;

    logic        in_sign_s;
    logic [31:0] in_mag_s;
    logic [31:0] norm_s;
    logic [23:0] sig_s;
    logic        guard_s;
    logic        sticky_s;
    logic        inc_s;
    logic [24:0] sig_rnd_s;
    logic [7:0]  exp_s;
    logic [22:0] frac_s;

    // Stage 1: sign, magnitude (0x80000000 negates to itself), leading-zero count; hold on stall.
    always_comb begin
        in_sign_s  = src[31] & ~is_unsigned;
        in_mag_s   = in_sign_s ? (~src + 32'd1) : src;
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_mag_d   = s1_mag_q;
        s1_lz_d    = s1_lz_q;
        s1_zero_d  = s1_zero_q;
        s1_rm_d    = s1_rm_q;
        if (!stall) begin
            s1_valid_d = valid_in;
            s1_sign_d  = in_sign_s;
            s1_mag_d   = in_mag_s;
            s1_lz_d    = clz32(in_mag_s);
            s1_zero_d  = (in_mag_s == 32'd0);
            s1_rm_d    = round_mode;
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Stage 2: normalize, round, pack; a zero magnitude bypasses to +0.0 with no flags.
    always_comb begin
        norm_s   = s1_mag_q << s1_lz_q;
        sig_s    = norm_s[31:8];
        guard_s  = norm_s[7];
        sticky_s = |norm_s[6:0];
        case (s1_rm_q)
            RM_RNE:  inc_s = guard_s & (sticky_s | sig_s[0]);
            RM_RTZ:  inc_s = 1'b0;
            RM_RDN:  inc_s = s1_sign_q & (guard_s | sticky_s);
            RM_RUP:  inc_s = ~s1_sign_q & (guard_s | sticky_s);
            RM_RMM:  inc_s = guard_s;
            default: inc_s = guard_s & (sticky_s | sig_s[0]);
        endcase
        sig_rnd_s = {1'b0, sig_s} + {24'd0, inc_s};
        exp_s     = 8'd158 - {3'b000, s1_lz_q};
        if (sig_rnd_s[24]) begin
            exp_s  = exp_s + 8'd1;
            frac_s = 23'd0;
        end else begin
            frac_s = sig_rnd_s[22:0];
        end

        valid_out_d = valid_out_q;
        result_d    = result_q;
        fflags_d    = fflags_q;
        if (!stall) begin
            valid_out_d = s1_valid_q;
            if (s1_zero_q) begin
                result_d = 32'd0;
                fflags_d = 5'd0;
            end else begin
                result_d = {s1_sign_q, exp_s, frac_s};
                fflags_d = {4'b0000, guard_s | sticky_s};
            end
        end else begin
            valid_out_d = valid_out_q;
        end
    end

    // Pipeline registers; reset clears both valid bits and the visible outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_mag_q    <= 32'd0;
            s1_lz_q     <= 5'd0;
            s1_zero_q   <= 1'b0;
            s1_rm_q     <= 3'd0;
            valid_out_q <= 1'b0;
            result_q    <= 32'd0;
            fflags_q    <= 5'd0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_mag_q    <= s1_mag_d;
            s1_lz_q     <= s1_lz_d;
            s1_zero_q   <= s1_zero_d;
            s1_rm_q     <= s1_rm_d;
            valid_out_q <= valid_out_d;
            result_q    <= result_d;
            fflags_q    <= fflags_d;
        end
    end

    assign valid_out = valid_out_q;
    assign result    = result_q;
    assign fflags    = fflags_q;

endmodule

// File: tb/tb_fcvt_int_to_fp.sv
// Directed self-checking bench for fcvt_int_to_fp: conversions, rounding, zero, stall, reset.
module tb_fcvt_int_to_fp;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        valid_in;
    logic [31:0] src;
    logic        is_unsigned;
    logic [2:0]  round_mode;
    logic        valid_out;
    logic [31:0] result;
    logic [4:0]  fflags;

    int tests_run;
    int tests_failed;

    fcvt_int_to_fp dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .valid_in    (valid_in),
        .src         (src),
        .is_unsigned (is_unsigned),
        .round_mode  (round_mode),
        .valid_out   (valid_out),
        .result      (result),
        .fflags      (fflags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_op(input logic [31:0] s, input logic u, input logic [2:0] rm);
        src         = s;
        is_unsigned = u;
        round_mode  = rm;
        valid_in    = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0; stall = 1'b1; valid_in = 1'b1;
        src = 32'hFFFF_FFFF; is_unsigned = 1'b1; round_mode = 3'd0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (valid_out !== 1'b0 || result !== 32'd0 || fflags !== 5'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got v=%b r=%h f=%h expected v=0 r=00000000 f=00", valid_out, result, fflags);
        end
        stall = 1'b0; valid_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (valid_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release_idle: valid_out got %b expected 0", valid_out);
        end
    endtask

    task automatic test_basic;
        logic [31:0] srcs [3] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] exps [3] = '{32'h3F80_0000, 32'hBF80_0000, 32'hCF00_0000};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive_op(srcs[i], 1'b0, 3'd0);
            @(negedge clk);
            valid_in = 1'b0;
            tests_run++;
            if (valid_out !== 1'b0) begin
                tests_failed++;
                $display("FAIL basic_latency_early[%0d]: valid_out got %b expected 0", i, valid_out);
            end
            @(negedge clk);
            tests_run++;
            if (valid_out !== 1'b1 || result !== exps[i] || fflags !== 5'd0) begin
                tests_failed++;
                $display("FAIL basic[%0d]: got v=%b r=%h f=%h expected v=1 r=%h f=00", i, valid_out, result, fflags, exps[i]);
            end
        end
    endtask

    task automatic test_rounding;
        logic        uns  [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [2:0]  rms  [12] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd3, 3'd4, 3'd2, 3'd7, 3'd5, 3'd1, 3'd0};
        logic [31:0] srcs [12] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                   32'h0100_0001, 32'h0100_0001, 32'h0100_0001, 32'hFEFF_FFFF,
                                   32'h0100_0001, 32'hFFFF_FFFF, 32'hFEFF_FFFF, 32'h0100_0003};
        logic [31:0] exps [12] = '{32'h4F80_0000, 32'h4F7F_FFFF, 32'h4F7F_FFFF, 32'h4F80_0000,
                                   32'h4B80_0000, 32'h4B80_0001, 32'h4B80_0001, 32'hCB80_0001,
                                   32'h4B80_0000, 32'h4F80_0000, 32'hCB80_0000, 32'h4B80_0002};
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive_op(srcs[i], uns[i], rms[i]);
            @(negedge clk);
            valid_in = 1'b0;
            @(negedge clk);
            tests_run++;
            if (valid_out !== 1'b1 || result !== exps[i] || fflags !== 5'h01) begin
                tests_failed++;
                $display("FAIL round[%0d] src=%h rm=%0d: got v=%b r=%h f=%h expected v=1 r=%h f=01",
                         i, srcs[i], rms[i], valid_out, result, fflags, exps[i]);
            end
        end
    endtask

    task automatic test_zero;
        for (int u = 0; u < 2; u++) begin
            for (int m = 0; m < 5; m++) begin
                @(negedge clk);
                drive_op(32'd0, u[0], m[2:0]);
                @(negedge clk);
                valid_in = 1'b0;
                @(negedge clk);
                tests_run++;
                if (valid_out !== 1'b1 || result !== 32'd0 || fflags !== 5'd0) begin
                    tests_failed++;
                    $display("FAIL zero u=%0d rm=%0d: got v=%b r=%h f=%h expected v=1 r=00000000 f=00",
                             u, m, valid_out, result, fflags);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        logic        uns  [3] = '{1'b0, 1'b1, 1'b0};
        logic [2:0]  rms  [3] = '{3'd0, 3'd3, 3'd2};
        logic [31:0] srcs [3] = '{32'h8000_0000, 32'h0100_0001, 32'hFEFF_FFFF};
        logic [31:0] exps [3] = '{32'hCF00_0000, 32'h4B80_0001, 32'hCB80_0001};
        logic [4:0]  efs  [3] = '{5'h00, 5'h01, 5'h01};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k >= 2 && k < 5) begin
                tests_run++;
                if (valid_out !== 1'b1 || result !== exps[k-2] || fflags !== efs[k-2]) begin
                    tests_failed++;
                    $display("FAIL b2b[%0d]: got v=%b r=%h f=%h expected v=1 r=%h f=%h",
                             k-2, valid_out, result, fflags, exps[k-2], efs[k-2]);
                end
            end else if (k == 5) begin
                tests_run++;
                if (valid_out !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL b2b_tail: valid_out got %b expected 0", valid_out);
                end
            end
            if (k < 3) drive_op(srcs[k], uns[k], rms[k]);
            else valid_in = 1'b0;
        end
    endtask

    task automatic test_stall;
        logic        ev [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] er [7] = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000,
                                32'hBF80_0000, 32'h4F7F_FFFF, 32'h0000_0000};
        logic [4:0]  ef [7] = '{5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h01, 5'h00};
        @(negedge clk);
        drive_op(32'h0000_0001, 1'b0, 3'd0);
        @(negedge clk);
        drive_op(32'hFFFF_FFFF, 1'b0, 3'd0);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            tests_run++;
            if (valid_out !== ev[k] || (ev[k] && (result !== er[k] || fflags !== ef[k]))) begin
                tests_failed++;
                $display("FAIL stall[%0d]: got v=%b r=%h f=%h expected v=%b r=%h f=%h",
                         k, valid_out, result, fflags, ev[k], er[k], ef[k]);
            end
            if (k == 0) begin
                stall = 1'b1;
                drive_op(32'hFFFF_FFFF, 1'b1, 3'd1);
            end else if (k == 3) begin
                stall = 1'b0;
            end else if (k == 4) begin
                valid_in = 1'b0;
            end
        end
    endtask

    task automatic test_reset_flush;
        @(negedge clk);
        drive_op(32'hFFFF_FFFF, 1'b1, 3'd0);
        @(negedge clk);
        drive_op(32'h0100_0001, 1'b0, 3'd3);
        @(posedge clk);
        #2;
        tests_run++;
        if (valid_out !== 1'b1 || result !== 32'h4F80_0000) begin
            tests_failed++;
            $display("FAIL flush_inflight: got v=%b r=%h expected v=1 r=4f800000", valid_out, result);
        end
        rst = 1'b0;
        valid_in = 1'b0;
        #1;
        tests_run++;
        if (valid_out !== 1'b0 || result !== 32'd0 || fflags !== 5'd0) begin
            tests_failed++;
            $display("FAIL flush_async: got v=%b r=%h f=%h expected v=0 r=00000000 f=00", valid_out, result, fflags);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests_run++;
            if (valid_out !== 1'b0) begin
                tests_failed++;
                $display("FAIL flush_no_ghost[%0d]: valid_out got %b expected 0", k, valid_out);
            end
        end
        @(negedge clk);
        drive_op(32'hFEFF_FFFF, 1'b0, 3'd2);
        @(negedge clk);
        valid_in = 1'b0;
        @(negedge clk);
        tests_run++;
        if (valid_out !== 1'b1 || result !== 32'hCB80_0001 || fflags !== 5'h01) begin
            tests_failed++;
            $display("FAIL post_reset_op: got v=%b r=%h f=%h expected v=1 r=cb800001 f=01", valid_out, result, fflags);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_basic();
        test_rounding();
        test_zero();
        test_back_to_back();
        test_stall();
        test_reset_flush();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fcvt_int_to_fp.md
FCVT_INT_TO_FP -- requirements
Module: fcvt_int_to_fp

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  pipeline hold.
- valid_in  in  1  input operand valid.
- src  in  32  integer operand.
- is_unsigned  in  1  1 means src is uint32; 0 means src is int32 (two's complement).
- round_mode  in  3  000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM.
- valid_out  out  1  result valid.
- result  out  32  IEEE-754 binary32 result.
- fflags  out  5  {NV,DZ,OF,UF,NX}.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset; all outputs SHALL be registered.

Function
REQ-003 The block SHALL be a 2-stage pipeline; a sample taken at edge N with stall=0 SHALL appear on valid_out/result/fflags after edge N+1, giving latency 2 cycles and throughput 1 per cycle.
REQ-004 Stage 1 SHALL register the following:
- valid bit;
- sign (src[31] & ~is_unsigned);
- 32-bit magnitude (negated src when sign=1; 0x80000000 stays 0x80000000);
- 5-bit leading-zero count of the magnitude;
- zero flag;
- round_mode.
REQ-005 Stage 2 SHALL perform the following steps:
- left-normalize the magnitude by the lz count;
- take the 24 MSBs as the significand;
- take guard = next bit and sticky = OR of the remaining 7 bits;
- round;
- pack sign, exponent = 158 - lz, and the 23-bit fraction.
REQ-006 Rounding SHALL increment the significand under these conditions:
- RNE: G&(S|LSB).
- RTZ: never.
- RDN: sign&(G|S).
- RUP: ~sign&(G|S).
- RMM: G.
REQ-007 A rounding carry out of the 24-bit significand SHALL increment the exponent by 1 and set the fraction to 0.
REQ-008 round_mode codes 101-111 SHALL be treated as RNE.
REQ-009 fflags.NX SHALL equal G|S of a valid conversion. NV, DZ, OF and UF SHALL always be 0; int32/uint32 cannot overflow binary32.
REQ-010 A zero source SHALL produce 0x00000000 (+0.0) with fflags=0 in every rounding mode.
REQ-011 valid_out SHALL be the stage-2 valid bit.
REQ-012 result and fflags SHALL be don't-care when valid_out=0, but SHALL remain deterministic (registered) values.
REQ-013 While stall=1, both stage registers, including the valid bits, SHALL hold their values.
REQ-014 While stall=1, valid_in SHALL be ignored; upstream holds its operand.
REQ-015 When stall deasserts, the held operation SHALL advance with no loss or duplication.
REQ-016 valid_in=0 with stall=0 SHALL insert a bubble (stage-1 valid=0); the data registers MAY update.
REQ-017 There SHALL be no combinational path from any input to any output.

Reset
REQ-018 While rst=0, both valid bits, result and fflags SHALL be 0, asynchronously and regardless of clk and stall.
REQ-019 Reset asserted mid-operation SHALL discard all in-flight conversions; no valid_out SHALL appear for them after release.
REQ-020 Following release, the first sample SHALL occur on the first rising edge with rst=1.

Verification
REQ-021 Basic conversions (RNE, no stall) SHALL be covered:
- signed src=0x00000001 -> 0x3F800000, NX=0;
- signed src=0xFFFFFFFF -> 0xBF800000;
- signed src=0x80000000 -> 0xCF000000, NX=0;
- each result with valid_out exactly 2 cycles after valid_in.
REQ-022 Rounding carry into the exponent SHALL be covered for unsigned src=0xFFFFFFFF:
- RNE -> 0x4F800000, NX=1;
- RTZ -> 0x4F7FFFFF, NX=1;
- RDN -> 0x4F7FFFFF;
- RUP -> 0x4F800000.
REQ-023 The tie case SHALL be covered for src=0x01000001 (16777217):
- signed RNE -> 0x4B800000, NX=1;
- RUP -> 0x4B800001;
- RMM -> 0x4B800001;
- signed src=0xFEFFFFFF (-16777217) with RDN -> 0xCB800001.
REQ-024 Zero SHALL be covered: src=0 in all 5 modes, signed and unsigned -> result 0x00000000, fflags 0x00.
REQ-025 Stall SHALL be covered:
- issue back-to-back ops A, B, C;
- assert stall for 3 cycles after B is accepted;
- valid_out SHALL present A, B and C in order, each exactly once, with A or B held steady while stalled.
REQ-026 Reset SHALL be covered:
- drive rst=0 asynchronously between edges with two ops in flight;
- valid_out, result and fflags SHALL go to 0 immediately;
- no valid_out SHALL appear for the flushed ops after release.
